rect_gravity_ctl: RTL and testbench

- Control stage placed directly after the mouse position source (real mouse interface or the simulation mouse stimulus generator). It drives the on-screen rectangle position into the rectangle draw stage.
- While idle, the rectangle follows the mouse.
- A left-button press releases the rectangle. It then falls under constant acceleration and bounces off the screen floor with halved velocity until it comes to rest.

---
 rtl/rect_gravity_ctl_if.sv | 20 ++
 rtl/rect_gravity_ctl.sv | 188 ++++++++++++++++++
 tb/tb_rect_gravity_ctl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/rect_gravity_ctl_if.sv
// Mouse-to-rectangle bus: the mouse position source drives the inputs, and the
// gravity controller drives the rectangle position back to the draw stage.
interface rect_gravity_ctl_if;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic        mouse_left;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        busy;

    modport master (
        output mouse_xpos, mouse_ypos, mouse_left,
        input  xpos, ypos, busy
    );

    modport slave (
        input  mouse_xpos, mouse_ypos, mouse_left,
        output xpos, ypos, busy
    );
endinterface

// File: rtl/rect_gravity_ctl.sv
// Rectangle position controller: follows the mouse while idle; after a left
// click it falls under constant acceleration and bounces off the floor.
module rect_gravity_ctl #(
    parameter int SCREEN_H = 600,
    parameter int RECT_H   = 64,
    parameter int TICK_DIV = 400_000,
    parameter int G        = 1,
    parameter int VMIN     = 2,
    parameter int VMAX     = 255
) (
    input  logic               pclk,
    input  logic               rst,
    rect_gravity_ctl_if.slave  bus
);
    localparam logic [11:0] FLOOR = 12'(SCREEN_H - RECT_H);
    localparam int          CNT_W = $clog2(TICK_DIV + 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FALL   = 2'd1,
        ST_BOUNCE = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic             left_d_r;
    logic [11:0]      xpos_r;
    logic [11:0]      ypos_r;
    logic [11:0]      vel_r;
    logic             busy_r;
    logic [11:0]      xpos_nxt_s;
    logic [11:0]      ypos_nxt_s;
    logic [11:0]      vel_nxt_s;
    logic             busy_nxt_s;

    logic             press_s;
    logic             moving_s;
    logic             tick_s;
    logic [12:0]      fall_sum_s;
    logic             fall_hit_s;
    logic [11:0]      half_vel_s;
    logic             rebound_s;
    logic [12:0]      vel_inc_s;
    logic [11:0]      vel_sat_s;
    logic [11:0]      rise_y_s;
    logic             apex_s;
    logic [11:0]      clamp_y_s;

    assign press_s    = bus.mouse_left & ~left_d_r;
    assign moving_s   = (state_r == ST_FALL) || (state_r == ST_BOUNCE);
    assign tick_s     = moving_s && (cnt_r == TICK_LAST);

    // Fall step uses the old velocity; 13 bits so the sum can never wrap.
    assign fall_sum_s = {1'b0, ypos_r} + {1'b0, vel_r};
    assign fall_hit_s = fall_sum_s >= {1'b0, FLOOR};
    assign half_vel_s = {1'b0, vel_r[11:1]};
    assign rebound_s  = half_vel_s >= 12'(VMIN);
    assign vel_inc_s  = {1'b0, vel_r} + 13'(G);
    assign vel_sat_s  = (vel_inc_s > 13'(VMAX)) ? 12'(VMAX) : vel_inc_s[11:0];
    assign rise_y_s   = (vel_r >= ypos_r) ? 12'd0 : (ypos_r - vel_r);
    assign apex_s     = vel_r <= 12'(G);
    assign clamp_y_s  = (bus.mouse_ypos > FLOOR) ? FLOOR : bus.mouse_ypos;

    // State register
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; presses only matter in IDLE and STOP
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (press_s) begin
                    state_nxt_s = ST_FALL;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FALL: begin
                if (tick_s && fall_hit_s) begin
                    state_nxt_s = rebound_s ? ST_BOUNCE : ST_STOP;
                end else begin
                    state_nxt_s = ST_FALL;
                end
            end
            ST_BOUNCE: begin
                if (tick_s && apex_s) begin
                    state_nxt_s = ST_FALL;
                end else begin
                    state_nxt_s = ST_BOUNCE;
                end
            end
            ST_STOP: begin
                if (press_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output/datapath decode: position and velocity for the next cycle
    always_comb begin
        xpos_nxt_s = xpos_r;
        ypos_nxt_s = ypos_r;
        vel_nxt_s  = vel_r;
        case (state_r)
            ST_IDLE: begin
                if (press_s) begin
                    vel_nxt_s = 12'd0;
                end else begin
                    xpos_nxt_s = bus.mouse_xpos;
                    ypos_nxt_s = clamp_y_s;
                end
            end
            ST_FALL: begin
                if (tick_s && !fall_hit_s) begin
                    ypos_nxt_s = fall_sum_s[11:0];
                    vel_nxt_s  = vel_sat_s;
                end else if (tick_s) begin
                    ypos_nxt_s = FLOOR;
                    vel_nxt_s  = rebound_s ? half_vel_s : 12'd0;
                end else begin
                    vel_nxt_s  = vel_r;
                end
            end
            ST_BOUNCE: begin
                if (tick_s) begin
                    ypos_nxt_s = rise_y_s;
                    vel_nxt_s  = apex_s ? 12'd0 : (vel_r - 12'(G));
                end else begin
                    vel_nxt_s  = vel_r;
                end
            end
            ST_STOP: begin
                vel_nxt_s = vel_r;
            end
            default: begin
                vel_nxt_s = 12'd0;
            end
        endcase
        busy_nxt_s = (state_nxt_s == ST_FALL) || (state_nxt_s == ST_BOUNCE);
    end

    // Registered outputs and velocity
    always_ff @(posedge pclk) begin
        if (rst) begin
            xpos_r <= 12'd0;
            ypos_r <= 12'd0;
            vel_r  <= 12'd0;
            busy_r <= 1'b0;
        end else begin
            xpos_r <= xpos_nxt_s;
            ypos_r <= ypos_nxt_s;
            vel_r  <= vel_nxt_s;
            busy_r <= busy_nxt_s;
        end
    end

    // Motion tick divider and button edge history; the divider only runs while moving
    always_ff @(posedge pclk) begin
        if (rst) begin
            cnt_r    <= '0;
            left_d_r <= 1'b0;
        end else begin
            left_d_r <= bus.mouse_left;
            if (moving_s) begin
                cnt_r <= tick_s ? '0 : (cnt_r + CNT_W'(1));
            end else begin
                cnt_r <= '0;
            end
        end
    end

    assign bus.xpos = xpos_r;
    assign bus.ypos = ypos_r;
    assign bus.busy = busy_r;
endmodule

// File: tb/tb_rect_gravity_ctl.sv
// Self-checking bench for rect_gravity_ctl: a physics-level model is compared
// against the DUT every cycle, alongside hand-computed checkpoints.
module tb_rect_gravity_ctl;
    localparam int TICK_DIV = 4;
    localparam int G        = 1;
    localparam int VMIN     = 2;
    localparam int VMAX     = 255;
    localparam int FLOOR    = 600 - 64;

    localparam int M_IDLE = 0, M_FALL = 1, M_BOUNCE = 2, M_STOP = 3;

    typedef struct {
        int x;
        int y;
        int vel;
        int mode;
        int k;
        bit left_d;
    } mst_t;

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   check_en = 1'b0;
    mst_t m = '{0, 0, 0, M_IDLE, 0, 1'b0};

    rect_gravity_ctl_if bus ();

    rect_gravity_ctl #(
        .SCREEN_H(600), .RECT_H(64), .TICK_DIV(TICK_DIV),
        .G(G), .VMIN(VMIN), .VMAX(VMAX)
    ) dut (
        .pclk(pclk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 pclk = ~pclk;

    // Model: k counts cycles spent in motion; every TICK_DIV-th one is a physics step.
    function automatic mst_t step(mst_t s, bit r, int mx, int my, bit ml);
        mst_t n = s;
        bit press = ml && !s.left_d;
        int half;
        n.left_d = ml;
        if (r) begin
            n = '{0, 0, 0, M_IDLE, 0, 1'b0};
            return n;
        end
        if (s.mode == M_IDLE) begin
            if (press) begin
                n.mode = M_FALL; n.vel = 0; n.k = 0;
            end else begin
                n.x = mx; n.y = (my > FLOOR) ? FLOOR : my;
            end
        end else if (s.mode == M_STOP) begin
            if (press) n.mode = M_IDLE;
        end else begin
            n.k = s.k + 1;
            if (s.k % TICK_DIV == TICK_DIV - 1) begin
                if (s.mode == M_FALL) begin
                    if (s.y + s.vel < FLOOR) begin
                        n.y = s.y + s.vel;
                        n.vel = (s.vel + G > VMAX) ? VMAX : s.vel + G;
                    end else begin
                        n.y = FLOOR;
                        half = s.vel / 2;
                        if (half >= VMIN) begin n.vel = half; n.mode = M_BOUNCE; end
                        else begin n.vel = 0; n.mode = M_STOP; end
                    end
                end else begin
                    n.y = (s.y - s.vel < 0) ? 0 : s.y - s.vel;
                    if (s.vel <= G) begin n.vel = 0; n.mode = M_FALL; end
                    else n.vel = s.vel - G;
                end
            end
        end
        return n;
    endfunction

    always @(posedge pclk)
        m <= step(m, rst, int'(bus.mouse_xpos), int'(bus.mouse_ypos), bus.mouse_left);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge pclk) begin
        if (check_en) begin
            chk("xpos_vs_model", int'(bus.xpos), m.x);
            chk("ypos_vs_model", int'(bus.ypos), m.y);
            chk("busy_vs_model", int'(bus.busy), (m.mode == M_FALL || m.mode == M_BOUNCE) ? 1 : 0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic set_mouse(input int x, input int y);
        bus.mouse_xpos = 12'(x);
        bus.mouse_ypos = 12'(y);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        set_mouse(300, 400);
        bus.mouse_left = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check_en = 1'b1;
        chk("rst_x", int'(bus.xpos), 0);
        chk("rst_y", int'(bus.ypos), 0);
        chk("rst_busy", int'(bus.busy), 0);
        rst = 1'b0;
        cyc(1);
        chk("post_rst_x", int'(bus.xpos), 300);
        chk("post_rst_y", int'(bus.ypos), 400);

        set_mouse(100, 200); cyc(1);
        chk("track_x", int'(bus.xpos), 100);
        chk("track_y", int'(bus.ypos), 200);
        set_mouse(100, 590); cyc(1);
        chk("clamp_y", int'(bus.ypos), 536);

        // Release from the top of the screen
        set_mouse(50, 0); cyc(1);
        bus.mouse_left = 1'b1; cyc(1);
        chk("press_busy", int'(bus.busy), 1);
        chk("press_x", int'(bus.xpos), 50);
        set_mouse(700, 300);
        cyc(4 * 33);
        chk("tick33_y", int'(bus.ypos), 528);
        chk("model_tick33_y", m.y, 528);
        chk("frozen_x", int'(bus.xpos), 50);
        cyc(4);
        chk("tick34_y", int'(bus.ypos), 536);
        chk("model_tick34_vel", m.vel, 16);
        chk("model_tick34_mode", m.mode, M_BOUNCE);

        // Button wiggle during BOUNCE, re-press landing on a tick edge
        cyc(30);
        bus.mouse_left = 1'b0; cyc(1);
        bus.mouse_left = 1'b1; cyc(33);
        chk("apex_y", int'(bus.ypos), 400);
        chk("apex_busy", int'(bus.busy), 1);
        chk("model_apex_mode", m.mode, M_FALL);

        for (int i = 0; i < 2000 && bus.busy; i++) cyc(1);
        chk("settle_busy", int'(bus.busy), 0);
        chk("settle_y", int'(bus.ypos), 536);
        chk("model_settle_mode", m.mode, M_STOP);

        // Held button stays ignored in STOP; a fresh press returns to IDLE
        set_mouse(123, 456); cyc(3);
        chk("stop_hold_x", int'(bus.xpos), 50);
        bus.mouse_left = 1'b0; cyc(1);
        bus.mouse_left = 1'b1; cyc(1);
        chk("stop_press_x", int'(bus.xpos), 50);
        cyc(1);
        chk("resume_x", int'(bus.xpos), 123);
        chk("resume_y", int'(bus.ypos), 456);

        // Reset mid-fall
        bus.mouse_left = 1'b0; set_mouse(50, 0); cyc(1);
        bus.mouse_left = 1'b1; cyc(1);
        cyc(4 * 20);
        chk("midfall_y", int'(bus.ypos), 190);
        cyc(2);
        rst = 1'b1; cyc(1);
        chk("midrst_x", int'(bus.xpos), 0);
        chk("midrst_y", int'(bus.ypos), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        rst = 1'b0; bus.mouse_left = 1'b0; set_mouse(10, 20); cyc(1);
        chk("after_rst_x", int'(bus.xpos), 10);
        chk("after_rst_y", int'(bus.ypos), 20);
        cyc(20);
        chk("no_residual_busy", int'(bus.busy), 0);
        chk("no_residual_y", int'(bus.ypos), 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
